mul_sum_pipe: RTL and testbench

- Downstream stage of the combinational `mul` partial-product block.
- Takes the carry-save pair mul_add_a/mul_add_b (66-bit, signed-extended 33x33 product form) plus the opcode.
- Adds the pair across two pipeline stages: low 33 bits in stage 1, high 33 bits plus carry in stage 2.
- Selects the low or high 32-bit word per opcode and returns it to the EX/WB path with a valid/ready handshake and rd tag.

---
 rtl/mul_sum_pipe.sv | 180 ++++++++++++++++++
 tb/tb_mul_sum_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sum_pipe.sv
// mul_sum_pipe
//   Carry-propagate adder stage behind the `mul` partial-product block. The
//   carry-save pair (mul_add_a, mul_add_b) is summed and the low or high
//   32-bit product word is returned with a valid/ready handshake and an rd
//   tag.
//
//   Default build: two-stage split-carry adder. Stage 1 adds the low
//   LO_WIDTH bits and registers the carry. Stage 2 adds the high bits plus
//   that carry and selects the output word.
//
//   Optional build macro MUL_SINGLE_STAGE_EN: the full-width add is done in
//   one stage, giving a latency of one cycle. mul_busy then equals out_valid.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   flush             synchronous kill of every in-flight entry
//   in_valid/in_ready upstream handshake
//   mul_opcode        NOP/MUL/MULH/MULHU/MULHSU (selects the result word only)
//   mul_add_a/_b      carry-save operands, PP_WIDTH bits
//   in_rd             destination tag carried with the request
//   out_valid/ready   downstream handshake
//   out_result        selected 32-bit product word
//   out_rd            tag travelling with out_result
//   mul_busy          any stage holds a valid entry

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef MUL_OP_NOP
`define MUL_OP_NOP    3'd0
`define MUL_OP_MUL    3'd1
`define MUL_OP_MULH   3'd2
`define MUL_OP_MULHU  3'd3
`define MUL_OP_MULHSU 3'd4
`endif

module mul_sum_pipe #(
  parameter int PP_WIDTH  = 66,
  parameter int LO_WIDTH  = 33,
  parameter int TAG_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             mul_opcode,
  input  logic [PP_WIDTH-1:0]    mul_add_a,
  input  logic [PP_WIDTH-1:0]    mul_add_b,
  input  logic [TAG_WIDTH-1:0]   in_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`WORD_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]   out_rd,
  output logic                   mul_busy
);

  localparam int W        = `WORD_WIDTH;
  localparam int HI_WIDTH = PP_WIDTH - LO_WIDTH;

  // MUL returns the low word. All high-word opcodes share one select,
  // because signedness was already folded in upstream.
  function automatic logic [W-1:0] word_sel(input logic [2:0]          op,
                                            input logic [PP_WIDTH-1:0] prod);
    logic [W-1:0] w;
    if (op == `MUL_OP_MUL) w = prod[W-1:0];
    else                   w = prod[2*W-1:W];
    return w;
  endfunction

  logic accept;
  logic is_nop;

  assign is_nop = (mul_opcode == `MUL_OP_NOP);
  assign accept = in_valid & in_ready;

`ifdef MUL_SINGLE_STAGE_EN

  logic                 vld_p1;
  logic [W-1:0]         result_p1;
  logic [TAG_WIDTH-1:0] rd_p1;
  logic [PP_WIDTH-1:0]  sum_p0;

  assign in_ready  = (!vld_p1 | out_ready) & !flush;
  assign sum_p0    = mul_add_a + mul_add_b;
  assign out_valid = vld_p1;
  assign out_result = result_p1;
  assign out_rd    = rd_p1;
  assign mul_busy  = vld_p1;

  // ---- stage p0 -> p1: full-width add and word select ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      rd_p1     <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (!vld_p1 | out_ready) begin
      vld_p1 <= accept & !is_nop;
      if (accept & !is_nop) begin
        result_p1 <= word_sel(mul_opcode, sum_p0);
        rd_p1     <= in_rd;
      end
    end
  end

`else

  logic                 vld_p1, vld_p2;
  logic                 adv_p1, adv_p2;
  logic [LO_WIDTH:0]    lo_sum_p0;
  logic [LO_WIDTH-1:0]  lo_p1;
  logic                 carry_p1;
  logic [HI_WIDTH-1:0]  a_hi_p1, b_hi_p1;
  logic [2:0]           op_p1;
  logic [TAG_WIDTH-1:0] rd_p1;
  logic [HI_WIDTH-1:0]  hi_sum_p1;
  logic [PP_WIDTH-1:0]  prod_p1;
  logic [W-1:0]         result_p2;
  logic [TAG_WIDTH-1:0] rd_p2;

  assign adv_p2   = !vld_p2 | out_ready;
  assign adv_p1   = !vld_p1 | adv_p2;
  assign in_ready = adv_p1 & !flush;

  assign lo_sum_p0 = {1'b0, mul_add_a[LO_WIDTH-1:0]} + {1'b0, mul_add_b[LO_WIDTH-1:0]};
  assign hi_sum_p1 = a_hi_p1 + b_hi_p1 + HI_WIDTH'(carry_p1);
  assign prod_p1   = {hi_sum_p1, lo_p1};

  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_rd     = rd_p2;
  assign mul_busy   = vld_p1 | vld_p2;

  // ---- stage p0 -> p1: low-half add, carry captured ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      // A NOP is consumed here and never becomes a valid entry.
      vld_p1 <= accept & !is_nop;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lo_p1    <= lo_sum_p0[LO_WIDTH-1:0];
      carry_p1 <= lo_sum_p0[LO_WIDTH];
      a_hi_p1  <= mul_add_a[PP_WIDTH-1:LO_WIDTH];
      b_hi_p1  <= mul_add_b[PP_WIDTH-1:LO_WIDTH];
      op_p1    <= mul_opcode;
      rd_p1    <= in_rd;
    end
  end

  // ---- stage p1 -> p2: high-half add with carry, word select ----
  // The result registers are cleared on reset and hold their value across a
  // flush. Only the valid bit is killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      rd_p2     <= '0;
    end else if (flush) begin
      vld_p2 <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= word_sel(op_p1, prod_p1);
        rd_p2     <= rd_p1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_mul_sum_pipe.sv
`ifndef MUL_OP_NOP
`define MUL_OP_NOP    3'd0
`define MUL_OP_MUL    3'd1
`define MUL_OP_MULH   3'd2
`define MUL_OP_MULHU  3'd3
`define MUL_OP_MULHSU 3'd4
`endif

module tb_mul_sum_pipe;
  localparam int PPW = 66;
  localparam int TW  = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush, in_valid, in_ready, out_valid, out_ready, mul_busy;
  logic [2:0]     mul_opcode;
  logic [PPW-1:0] mul_add_a, mul_add_b;
  logic [TW-1:0]  in_rd, out_rd;
  logic [31:0]    out_result;

  int compares = 0;
  int fails    = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [31:0]   res;
    logic [TW-1:0] rd;
    int            edge_no;
  } entry_t;
  entry_t q[$];

  mul_sum_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mul_opcode(mul_opcode), .mul_add_a(mul_add_a), .mul_add_b(mul_add_b),
    .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: full-width sum modulo 2^66, then the opcode picks a word.
  function automatic logic [31:0] model_word(input logic [2:0] op,
                                             input logic [PPW-1:0] a,
                                             input logic [PPW-1:0] b);
    logic [PPW-1:0] s;
    s = a + b;
    return (op == `MUL_OP_MUL) ? s[31:0] : s[63:32];
  endfunction

  function automatic logic [PPW-1:0] rand_pp();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0: return '1;
      1: return '0;
      2: return {33'h0, 33'h1_FFFF_FFFF};
      default: return r[PPW-1:0];
    endcase
  endfunction

  // Compare process: the model holds the in-flight entries in order. The
  // head is visible one edge after it was captured, there are at most two
  // entries, and every output is checked on each cycle.
  initial begin
    logic           acc, pop, fl, exp_rdy, exp_vld;
    logic [31:0]    nres;
    logic [TW-1:0]  nrd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        continue;
      end
      exp_rdy = ((q.size() < 2) || out_ready) && !flush;
      exp_vld = (q.size() > 0) && (edge_cnt - q[0].edge_no >= 1);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(exp_vld));
      check("mul_busy", 64'(mul_busy), 64'(q.size() > 0));
      if (exp_vld && out_valid) begin
        check("out_result", 64'(out_result), 64'(q[0].res));
        check("out_rd", 64'(out_rd), 64'(q[0].rd));
      end
      acc  = in_valid && exp_rdy && (mul_opcode != `MUL_OP_NOP);
      nres = model_word(mul_opcode, mul_add_a, mul_add_b);
      nrd  = in_rd;
      pop  = exp_vld && out_ready;
      fl   = flush;
      @(posedge clk);
      edge_cnt++;
      if (!rst_n) begin
        q.delete();
        continue;
      end
      if (pop) void'(q.pop_front());
      if (fl) q.delete();
      else if (acc) q.push_back('{res: nres, rd: nrd, edge_no: edge_cnt});
    end
  end

  // Called at posedge+1. Returns at posedge+1 after the accepting edge.
  task automatic send(input logic [PPW-1:0] a, input logic [PPW-1:0] b,
                      input logic [2:0] op, input logic [TW-1:0] rd);
    bit ok = 0;
    mul_add_a = a; mul_add_b = b; mul_opcode = op; in_rd = rd; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1 rd=%0d", rd);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called with out_ready=1. Returns at posedge+1.
  task automatic expect_out(input string name, input logic [31:0] res, input logic [TW-1:0] rd);
    bit seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: out_valid stayed 0 expected 1", name);
    end else begin
      check({name, "_res"}, 64'(out_result), 64'(res));
      check({name, "_rd"}, 64'(out_rd), 64'(rd));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    flush = 0; in_valid = 0; out_ready = 1; mul_opcode = 0;
    mul_add_a = '0; mul_add_b = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_mul_busy", 64'(mul_busy), 64'd0);
    rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Basic MUL with an explicit two-edge latency check.
    send(66'd6, 66'd7, `MUL_OP_MUL, 5'd1);
    @(negedge clk);
    check("lat_early_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("basic_res", 64'(out_result), 64'd13);
    check("basic_rd", 64'(out_rd), 64'd1);
    @(posedge clk); #1;

    // Carry across the split point, and wraparound modulo 2^66.
    send(66'h1_FFFF_FFFF, 66'd1, `MUL_OP_MUL, 5'd2);
    expect_out("carry_mul", 32'h0, 5'd2);
    send(66'h1_FFFF_FFFF, 66'd1, `MUL_OP_MULH, 5'd3);
    expect_out("carry_mulh", 32'h2, 5'd3);
    send(66'h3_FFFF_FFFF_FFFF_FFFF, 66'd2, `MUL_OP_MUL, 5'd4);
    expect_out("wrap_mul", 32'h1, 5'd4);
    send(66'h3_FFFF_FFFF_FFFF_FFFF, 66'd2, `MUL_OP_MULH, 5'd5);
    expect_out("wrap_mulh", 32'h0, 5'd5);
    send(66'h0_1234_5678_0000_0000, 66'h0_0000_0001_0000_0000, `MUL_OP_MULHU, 5'd6);
    expect_out("mulhu", 32'h1234_5679, 5'd6);

    // Backpressure: two entries fill the pipe and the third request waits.
    out_ready = 0;
    send(66'd10, 66'd1, `MUL_OP_MUL, 5'd1);
    send(66'd20, 66'd2, `MUL_OP_MUL, 5'd2);
    mul_add_a = 66'd30; mul_add_b = 66'd3; mul_opcode = `MUL_OP_MUL; in_rd = 5'd3; in_valid = 1;
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_busy", 64'(mul_busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_rd", 64'(out_rd), 64'd1);
      check("bp_hold_res", 64'(out_result), 64'd11);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    check("bp_out1_rd", 64'(out_rd), 64'd1);
    check("bp_out1_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("bp_out2_vld", 64'(out_valid), 64'd1);
    check("bp_out2_rd", 64'(out_rd), 64'd2);
    check("bp_out2_res", 64'(out_result), 64'd22);
    @(negedge clk);
    check("bp_out3_vld", 64'(out_valid), 64'd1);
    check("bp_out3_rd", 64'(out_rd), 64'd3);
    check("bp_out3_res", 64'(out_result), 64'd33);
    @(posedge clk); #1;

    // A NOP is accepted but produces nothing.
    send(66'd1, 66'd2, `MUL_OP_NOP, 5'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nop_no_valid", 64'(out_valid), 64'd0);
      check("nop_busy", 64'(mul_busy), 64'd0);
    end
    @(posedge clk); #1;

    // Flush with two entries in flight.
    out_ready = 0;
    send(66'd100, 66'd5, `MUL_OP_MUL, 5'd8);
    send(66'd200, 66'd5, `MUL_OP_MUL, 5'd9);
    flush = 1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(mul_busy), 64'd0);
    check("flush_res_hold", 64'(out_result), 64'd105);
    @(posedge clk); #1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Asynchronous reset with entries in flight.
    out_ready = 0;
    send(66'd40, 66'd2, `MUL_OP_MUL, 5'd10);
    send(66'd50, 66'd3, `MUL_OP_MUL, 5'd11);
    #2 rst_n = 0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_res", 64'(out_result), 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    check("arst_busy", 64'(mul_busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    @(negedge clk);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(66'd9, 66'd6, `MUL_OP_MUL, 5'd12);
    expect_out("post_rst", 32'd15, 5'd12);

    // Randomized traffic with backpressure, NOPs and occasional flushes.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 39) == 0);
      mul_opcode = 3'($urandom_range(0, 4));
      mul_add_a  = rand_pp();
      mul_add_b  = rand_pp();
      in_rd      = TW'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
